// File: rtl/stage_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stage_seq_pkg
// Description : Shared types and default constants for the instruction stage
//               sequencer (state encoding, default stage count and decode
//               stage index).
// Revision    : 1.0 - initial release
// ============================================================================
package stage_seq_pkg;

  // Sequencer top-level states; SEQ_HALT is only reachable when the
  // watchdog is built in.
  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_RUN  = 2'd1,
    SEQ_HALT = 2'd2
  } seq_state_e;

  // Default pipeline shape: IF/ID/EX/MEM/WB with decode at stage 1.
  localparam int SEQ_NSTAGES   = 5;
  localparam int SEQ_DEC_STAGE = 1;

endpackage : stage_seq_pkg
`default_nettype wire

// File: rtl/seq_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : seq_delay_line
// Description : 1-bit shift register of parametrised depth with asynchronous
//               active-low clear. Each input pulse reappears on q exactly
//               DEPTH cycles later; back-to-back pulses are all preserved.
// Ports       : clk  - clock
//               rst  - asynchronous active-low clear
//               d    - input bit
//               q    - input bit delayed by DEPTH cycles
// Revision    : 1.0 - initial release
// ============================================================================
module seq_delay_line
  import stage_seq_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] r_sr;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_sr <= '0;
        else      r_sr <= d;
      end
    end else begin : g_chain
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_sr <= '0;
        else      r_sr <= {r_sr[DEPTH-2:0], d};
      end
    end
  endgenerate

  assign q = r_sr[DEPTH-1];

endmodule : seq_delay_line
`default_nettype wire

// File: rtl/stage_seq.sv
`default_nettype none
// ============================================================================
// Module      : stage_seq
// Description : Multi-cycle instruction sequencer. Steps one instruction at a
//               time through NSTAGES stages with one-cycle start pulses and
//               per-stage finish handshakes, skips stages flagged at decode,
//               and emits a delayed commit pulse plus a retire count.
// Build macro : STAGE_SEQ_WDOG_EN - adds a stall watchdog that parks the
//               sequencer in SEQ_HALT after WDOG_LIMIT cycles without an
//               accepted finish (exit only on reset).
// Ports       : clk            - clock
//               rst            - asynchronous active-low reset
//               run_i          - allow starting a new instruction
//               halt_i         - stop at the next instruction boundary
//               stage_finish_i - per-stage done handshake
//               skip_i         - per-stage skip flags, sampled at decode finish
//               stage_valid_o  - per-stage one-cycle start pulse
//               cur_stage_o    - index of the active stage
//               busy_o         - instruction in flight
//               commit_o       - pulse COMMIT_DELAY cycles after retire
//               retire_cnt_o   - retired instruction count (wraps)
//               wdog_o         - sticky watchdog flag
// Revision    : 1.0 - initial release
// ============================================================================
module stage_seq
  import stage_seq_pkg::*;
#(
  parameter int NSTAGES      = SEQ_NSTAGES,
  parameter int DEC_STAGE    = SEQ_DEC_STAGE,
  parameter int COMMIT_DELAY = 2,
  parameter int CNT_W        = 64,
  parameter int WDOG_LIMIT   = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       run_i,
  input  logic                       halt_i,
  input  logic [NSTAGES-1:0]         stage_finish_i,
  input  logic [NSTAGES-1:0]         skip_i,
  output logic [NSTAGES-1:0]         stage_valid_o,
  output logic [$clog2(NSTAGES)-1:0] cur_stage_o,
  output logic                       busy_o,
  output logic                       commit_o,
  output logic [CNT_W-1:0]           retire_cnt_o,
  output logic                       wdog_o
);

  localparam int IDX_W = $clog2(NSTAGES);
  typedef logic [IDX_W-1:0] stage_idx_t;

  localparam stage_idx_t         C_DEC = stage_idx_t'(DEC_STAGE);
  // Stages up to and including decode can never be skipped.
  localparam logic [NSTAGES-1:0] C_SKIP_ALLOW = {NSTAGES{1'b1}} << (DEC_STAGE + 1);

  generate
    if (NSTAGES < 2 || DEC_STAGE >= NSTAGES) begin : g_chk_shape
      $error("stage_seq: NSTAGES must be >= 2 and DEC_STAGE < NSTAGES");
    end
    if (COMMIT_DELAY < 1 || WDOG_LIMIT < 1) begin : g_chk_delay
      $error("stage_seq: COMMIT_DELAY and WDOG_LIMIT must be >= 1");
    end
  endgenerate

  seq_state_e         r_state, w_state_nxt;
  stage_idx_t         r_cur, w_cur_nxt;
  logic [NSTAGES-1:0] r_mask, w_mask_nxt;
  logic               r_first, w_first_nxt;   // first cycle at current stage
  logic [CNT_W-1:0]   r_cnt;

  logic               w_fin;
  logic               w_retire;
  logic               w_found;
  stage_idx_t         w_scan;
  logic [NSTAGES-1:0] w_eff_mask;
  logic               w_wdog_trip;

  assign w_fin = (r_state == SEQ_RUN) && stage_finish_i[r_cur];

  // Next-unskipped-stage search. At the decode finish the freshly sampled
  // skip flags must steer the very next step, so they bypass r_mask here.
  always_comb begin
    w_eff_mask = (r_cur == C_DEC) ? (skip_i & C_SKIP_ALLOW) : r_mask;
    w_found    = 1'b0;
    w_scan     = '0;
    for (int i = NSTAGES - 1; i >= 0; i--) begin
      if (i > int'(r_cur) && !w_eff_mask[i]) begin
        w_found = 1'b1;
        w_scan  = stage_idx_t'(i);
      end
    end
  end

  assign w_retire = w_fin && !w_found;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= SEQ_IDLE;
      r_cur   <= '0;
      r_mask  <= '0;
      r_first <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cur   <= w_cur_nxt;
      r_mask  <= w_mask_nxt;
      r_first <= w_first_nxt;
      if (w_retire) r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur;
    w_mask_nxt  = r_mask;
    w_first_nxt = 1'b0;
    case (r_state)
      SEQ_IDLE: begin
        if (run_i && !halt_i) begin
          w_state_nxt = SEQ_RUN;
          w_cur_nxt   = '0;
          w_mask_nxt  = '0;
          w_first_nxt = 1'b1;
        end
      end
      SEQ_RUN: begin
        if (w_fin && r_cur == C_DEC) w_mask_nxt = w_eff_mask;
        if (w_retire) begin
          w_cur_nxt  = '0;
          w_mask_nxt = '0;
          if (halt_i || !run_i) w_state_nxt = SEQ_IDLE;
          else                  w_first_nxt = 1'b1;  // next fetch with no bubble
        end else if (w_fin) begin
          w_cur_nxt   = w_scan;
          w_first_nxt = 1'b1;
        end
        if (w_wdog_trip) begin
          w_state_nxt = SEQ_HALT;
          w_first_nxt = 1'b0;
        end
      end
      SEQ_HALT: begin
        // Parked until reset.
      end
      default: w_state_nxt = SEQ_IDLE;
    endcase
  end

`ifdef STAGE_SEQ_WDOG_EN
  localparam int WAIT_W = $clog2(WDOG_LIMIT + 1);

  logic [WAIT_W-1:0] r_wait;
  logic              r_wdog;

  // Counting restarts whenever a finish is accepted (i.e. on every stage
  // change or retire) and whenever the sequencer is not running.
  assign w_wdog_trip = (r_state == SEQ_RUN) && !w_fin &&
                       (r_wait == WAIT_W'(WDOG_LIMIT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wait <= '0;
      r_wdog <= 1'b0;
    end else begin
      if (r_state != SEQ_RUN || w_fin) r_wait <= '0;
      else if (!w_wdog_trip)           r_wait <= r_wait + 1'b1;
      if (w_wdog_trip) r_wdog <= 1'b1;
    end
  end

  assign wdog_o = r_wdog;
`else
  assign w_wdog_trip = 1'b0;
  assign wdog_o      = 1'b0;
`endif

  seq_delay_line #(
    .DEPTH (COMMIT_DELAY)
  ) u_commit_dly (
    .clk (clk),
    .rst (rst),
    .d   (w_retire),
    .q   (commit_o)
  );

  assign stage_valid_o = (r_state == SEQ_RUN && r_first) ? (NSTAGES'(1) << r_cur) : '0;
  assign cur_stage_o   = r_cur;
  assign busy_o        = (r_state == SEQ_RUN);
  assign retire_cnt_o  = r_cnt;

endmodule : stage_seq
`default_nettype wire

// File: tb/tb_stage_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_stage_seq
// Description : Self-checking bench for stage_seq. Drives instructions through
//               the stage handshake, checks pulses against a stage-list model
//               and checks commit pulses against a scoreboard of expected
//               commit cycles. The STAGE_SEQ_WDOG_EN macro selects which
//               stall behaviour is expected.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stage_seq;
  import stage_seq_pkg::*;

  localparam int NS   = 5;
  localparam int CDLY = 2;
  localparam int WLIM = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          run_i = 1'b0;
  logic          halt_i = 1'b0;
  logic [NS-1:0] stage_finish_i = '0;
  logic [NS-1:0] skip_i = '0;
  logic [NS-1:0] stage_valid_o;
  logic [2:0]    cur_stage_o;
  logic          busy_o;
  logic          commit_o;
  logic [63:0]   retire_cnt_o;
  logic          wdog_o;

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          commit_q[$];
  int          sb_exp;
  logic [63:0] exp_cnt = '0;
  logic        seen_p;
  logic        seen_w;

  stage_seq #(
    .NSTAGES      (NS),
    .DEC_STAGE    (1),
    .COMMIT_DELAY (CDLY),
    .CNT_W        (64),
    .WDOG_LIMIT   (WLIM)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .run_i          (run_i),
    .halt_i         (halt_i),
    .stage_finish_i (stage_finish_i),
    .skip_i         (skip_i),
    .stage_valid_o  (stage_valid_o),
    .cur_stage_o    (cur_stage_o),
    .busy_o         (busy_o),
    .commit_o       (commit_o),
    .retire_cnt_o   (retire_cnt_o),
    .wdog_o         (wdog_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard consumer: every commit pulse must match the oldest expected cycle.
  always @(negedge clk) begin
    if (commit_o === 1'b1) begin
      if (commit_q.size() == 0) begin
        chk("commit_unexpected", commit_o, 1'b0);
      end else begin
        sb_exp = commit_q.pop_front();
        chk("commit_cycle", cyc, sb_exp);
      end
    end
  end

  // Drives one instruction. lat: cycles from pulse to finish. gap0: expected
  // wait for the first pulse. stop: drop run_i with the final finish.
  // nfin: stages to finish before returning at the next pulse. halt_at: stage
  // whose pulse raises halt_i. push: expect a commit for this retire.
  task automatic run_instr(input logic [NS-1:0] skip, input int lat, input int gap0,
                           input bit stop, input int nfin, input int halt_at, input bit push);
    int            stg[$];
    int            n;
    logic [NS-1:0] ev;
    logic [NS-1:0] fv;
    for (int i = 0; i < NS; i++) if (i <= 1 || !skip[i]) stg.push_back(i);
    for (int k = 0; k < stg.size(); k++) begin
      n = 0;
      while (stage_valid_o == '0 && n < 40) begin
        @(negedge clk);
        n++;
      end
      ev = '0;
      ev[stg[k]] = 1'b1;
      chk("pulse", stage_valid_o, ev);
      chk("cur_stage", cur_stage_o, stg[k]);
      chk("pulse_gap", n, (k == 0) ? gap0 : 0);
      if (stg[k] == halt_at) halt_i = 1'b1;
      if (k >= nfin) return;
      if (lat > 0) begin
        @(negedge clk);
        chk("pulse_once", stage_valid_o, '0);
        repeat (lat - 1) @(negedge clk);
      end
      fv = '0;
      fv[stg[k]] = 1'b1;
      stage_finish_i = fv;
      if (stg[k] == 1) skip_i = skip;
      if (k == stg.size() - 1) begin
        if (stop) run_i = 1'b0;
        if (push) commit_q.push_back(cyc + CDLY);
        exp_cnt++;
      end
      @(negedge clk);
      stage_finish_i = '0;
      skip_i = '0;
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", stage_valid_o, '0);
    chk("rst_cur", cur_stage_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_commit", commit_o, 0);
    chk("rst_cnt", retire_cnt_o, 0);
    chk("rst_wdog", wdog_o, 0);
    rst = 1'b1;
    @(negedge clk);

    // 1: plain instruction, finish one cycle after each pulse
    run_i = 1'b1;
    run_instr('0, 1, 1, 1'b1, NS, -1, 1'b1);
    chk("t1_busy", busy_o, 0);
    chk("t1_cnt", retire_cnt_o, exp_cnt);
    repeat (3) @(negedge clk);

    // 2: skip MEM; then an attempt to skip IF/ID which must be ignored
    run_i = 1'b1;
    run_instr(5'b01000, 1, 1, 1'b1, NS, -1, 1'b1);
    repeat (3) @(negedge clk);
    run_i = 1'b1;
    run_instr(5'b00011, 1, 1, 1'b1, NS, -1, 1'b1);
    chk("t2_cnt", retire_cnt_o, exp_cnt);
    repeat (3) @(negedge clk);

    // 3: finishes in the pulse cycle, three back-to-back instructions
    run_i = 1'b1;
    run_instr('0, 0, 1, 1'b0, NS, -1, 1'b1);
    run_instr('0, 0, 0, 1'b0, NS, -1, 1'b1);
    run_instr('0, 0, 0, 1'b1, NS, -1, 1'b1);
    chk("t3_busy", busy_o, 0);
    chk("t3_cnt", retire_cnt_o, exp_cnt);
    repeat (4) @(negedge clk);

    // 4: halt raised during EX completes the instruction, then holds IDLE
    run_i = 1'b1;
    run_instr('0, 1, 1, 1'b0, NS, 2, 1'b1);
    chk("t4_busy", busy_o, 0);
    seen_p = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen_p |= |stage_valid_o;
    end
    chk("t4_no_fetch", seen_p, 0);
    chk("t4_cnt", retire_cnt_o, exp_cnt);
    halt_i = 1'b0;
    run_instr('0, 1, 1, 1'b1, NS, -1, 1'b1);
    repeat (4) @(negedge clk);

    // 5a: reset between edges while MEM is active
    run_i = 1'b1;
    run_instr('0, 0, 1, 1'b0, 3, -1, 1'b1);
    #2 rst = 1'b0;
    exp_cnt = '0;
    #1;
    chk("t5_valid", stage_valid_o, '0);
    chk("t5_busy", busy_o, 0);
    chk("t5_cur", cur_stage_o, 0);
    chk("t5_cnt", retire_cnt_o, exp_cnt);
    run_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    // 5b: reset while a commit is still in the delay line
    run_i = 1'b1;
    run_instr('0, 0, 1, 1'b1, NS, -1, 1'b0);
    #2 rst = 1'b0;
    exp_cnt = '0;
    #1;
    chk("t5b_cnt", retire_cnt_o, exp_cnt);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("t5b_cnt_after", retire_cnt_o, exp_cnt);

    // 6: EX finish withheld
    run_i = 1'b1;
    run_instr('0, 1, 1, 1'b0, 2, -1, 1'b1);
`ifdef STAGE_SEQ_WDOG_EN
    repeat (WLIM - 1) @(negedge clk);
    chk("t6_wdog_early", wdog_o, 0);
    @(negedge clk);
    chk("t6_wdog", wdog_o, 1);
    chk("t6_busy", busy_o, 0);
    seen_p = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen_p |= |stage_valid_o;
    end
    chk("t6_no_pulse", seen_p, 0);
    chk("t6_wdog_sticky", wdog_o, 1);
`else
    seen_p = 1'b0;
    seen_w = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen_p |= |stage_valid_o;
      seen_w |= wdog_o;
    end
    chk("t6_no_wdog", seen_w, 0);
    chk("t6_busy", busy_o, 1);
    chk("t6_no_pulse", seen_p, 0);
`endif
    run_i = 1'b0;
    repeat (4) @(negedge clk);
    chk("sb_empty", commit_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule : tb_stage_seq
`default_nettype wire
